// File: rtl/fp_div_pkg.sv
// Shared definitions for the FP32 divide datapath: operand class codes,
// exception flag bit positions, exponent limits and default widths.
`timescale 1ns/1ps

package fp_div_pkg;

    localparam int QW_DEF  = 26;
    localparam int EW_DEF  = 10;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Positions within the 5-bit flag vector {invalid, divzero, overflow, underflow, inexact}
    localparam int FLG_INEXACT   = 0;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_INVALID   = 4;

endpackage

// File: rtl/fp_div_rne_round.sv
// Round-to-nearest-even on a normalized 24-bit mantissa.
// Ports:
//   mant_i/guard_i/sticky_i/exp_i : normalized mantissa, guard bit, sticky bit, signed exponent
//   mant_o/exp_o                  : rounded mantissa (renormalized on carry-out) and exponent
//   inexact_o                     : any discarded bit was nonzero
// Pure combinational; overflow/underflow decisions are left to the caller.
`timescale 1ns/1ps

module fp_div_rne_round
    import fp_div_pkg::*;
#(
    parameter int EW = EW_DEF
) (
    input  logic [23:0]          mant_i,
    input  logic                 guard_i,
    input  logic                 sticky_i,
    input  logic signed [EW-1:0] exp_i,
    output logic [23:0]          mant_o,
    output logic signed [EW-1:0] exp_o,
    output logic                 inexact_o
);

    logic        inc;
    logic [24:0] m25;

    always_comb begin
        inc       = guard_i & (sticky_i | mant_i[0]);
        m25       = {1'b0, mant_i} + {24'd0, inc};
        inexact_o = guard_i | sticky_i;
        // Carry-out only happens from 0xFFFFFF, so the result is exactly 1.0 * 2^(exp+1)
        if (m25[24]) begin
            mant_o = 24'h80_0000;
            exp_o  = exp_i + EW'(1);
        end else begin
            mant_o = m25[23:0];
            exp_o  = exp_i;
        end
    end

endmodule

// File: rtl/fp_div_round_pack.sv
// FP32 divide back end: normalize (stage 1), round/pack with flags (stage 2).
// Two-stage valid/ready pipeline, latency 2, one result per cycle.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : upstream handshake (in_ready combinational from out_ready)
//   in_sign/in_exp/in_quot   : sign, signed biased exponent, raw mantissa quotient
//   in_rem_nz                : divider remainder nonzero
//   in_class/in_exc          : pre-decided special class, {invalid, divzero}
//   out_valid/out_ready      : downstream handshake
//   out_result/out_flags     : packed FP32, {invalid, divzero, overflow, underflow, inexact}
`timescale 1ns/1ps

module fp_div_round_pack
    import fp_div_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [EW-1:0] in_exp,
    input  logic [QW-1:0]        in_quot,
    input  logic                 in_rem_nz,
    input  logic [1:0]           in_class,
    input  logic [1:0]           in_exc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [4:0]           out_flags
);

    // Quotient bits below the guard position fold into sticky
    localparam logic [QW-1:0] MASK_HI = (QW'(1) << (QW - 25)) - QW'(1);
    localparam logic [QW-1:0] MASK_LO = (QW'(1) << (QW - 26)) - QW'(1);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] EXP_ZERO_S = '0;

    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic signed [EW-1:0] s1_exp_q,  s1_exp_d;
    logic [23:0]          s1_mant_q, s1_mant_d;
    logic                 s1_guard_q, s1_guard_d;
    logic                 s1_sticky_q, s1_sticky_d;
    cls_e                 s1_cls_q;
    logic [1:0]           s1_exc_q;

    logic                 out_valid_q;
    logic [31:0]          out_result_q, res_d;
    logic [4:0]           out_flags_q, flags_d;

    logic                 s2_adv, s1_adv;

    logic [23:0]          r_mant;
    logic signed [EW-1:0] r_exp;
    logic                 r_inexact;
    logic                 unused_mant_msb;

    assign s2_adv    = !out_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    // Stage 1: quotient lies in (2^24, 2^26); shift so the leading one sits at bit 23
    always_comb begin
        if (in_quot[QW-1]) begin
            s1_mant_d   = in_quot[QW-1 -: 24];
            s1_guard_d  = in_quot[QW-25];
            s1_sticky_d = in_rem_nz | (|(in_quot & MASK_HI));
            s1_exp_d    = in_exp;
        end else begin
            s1_mant_d   = in_quot[QW-2 -: 24];
            s1_guard_d  = in_quot[QW-26];
            s1_sticky_d = in_rem_nz | (|(in_quot & MASK_LO));
            s1_exp_d    = in_exp - EW'(1);
        end
    end

    fp_div_rne_round #(.EW(EW)) u_round (
        .mant_i    (s1_mant_q),
        .guard_i   (s1_guard_q),
        .sticky_i  (s1_sticky_q),
        .exp_i     (s1_exp_q),
        .mant_o    (r_mant),
        .exp_o     (r_exp),
        .inexact_o (r_inexact)
    );

    // The hidden bit is implied in the packed format
    assign unused_mant_msb = r_mant[23];

    // Stage 2: specials override arithmetic; exception inputs always pass through
    always_comb begin
        flags_d              = '0;
        flags_d[FLG_INVALID] = s1_exc_q[1];
        flags_d[FLG_DIVZERO] = s1_exc_q[0];
        res_d                = '0;
        case (s1_cls_q)
            CLS_ZERO: res_d = {s1_sign_q, 31'd0};
            CLS_INF:  res_d = {s1_sign_q, 8'hFF, 23'd0};
            CLS_NAN:  res_d = QNAN;
            default: begin
                if (r_exp >= EXP_MAX_S) begin
                    res_d                  = {s1_sign_q, 8'hFF, 23'd0};
                    flags_d[FLG_OVERFLOW]  = 1'b1;
                    flags_d[FLG_INEXACT]   = 1'b1;
                end else if (r_exp <= EXP_ZERO_S) begin
                    res_d                  = {s1_sign_q, 31'd0};
                    flags_d[FLG_UNDERFLOW] = 1'b1;
                    flags_d[FLG_INEXACT]   = 1'b1;
                end else begin
                    res_d                  = {s1_sign_q, r_exp[7:0], r_mant[22:0]};
                    flags_d[FLG_INEXACT]   = r_inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_mant_q    <= '0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_cls_q     <= CLS_NORM;
            s1_exc_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q   <= in_sign;
                    s1_exp_q    <= s1_exp_d;
                    s1_mant_q   <= s1_mant_d;
                    s1_guard_q  <= s1_guard_d;
                    s1_sticky_q <= s1_sticky_d;
                    s1_cls_q    <= cls_e'(in_class);
                    s1_exc_q    <= in_exc;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q <= res_d;
                    out_flags_q  <= flags_d;
                end
            end
        end
    end

endmodule
